// File: rtl/primogen_drv.sv
// Initiator for the primogen go/ready/error/res handshake: collects a run of results
// into a local buffer for indexed readback and reports generator errors and stalls.
module primogen_drv #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 65535,
    parameter int TW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW:0]      count,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [AW:0]      n_valid,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             gen_go,
    input  logic             gen_ready,
    input  logic             gen_error,
    input  logic [WIDTH-1:0] gen_res
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_HIGH = 3'd1;
    localparam logic [2:0] S_CAPTURE   = 3'd2;
    localparam logic [2:0] S_GO        = 3'd3;
    localparam logic [2:0] S_WAIT_LOW  = 3'd4;
    localparam logic [2:0] S_FIN       = 3'd5;

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [AW:0]      r_target;
    logic [TW-1:0]    r_cnt;
    logic [AW:0]      r_n_valid;
    logic [1:0]       r_fail_code;
    logic             r_busy;
    logic             r_done;
    logic             r_fail;
    logic             r_gen_go;
    logic [WIDTH-1:0] r_rd_data;
    logic [WIDTH-1:0] r_buf [DEPTH];

    logic [AW:0] w_target;
    logic [AW:0] w_nv_inc;
    logic        w_timeout;
    logic        w_rd_hit;

    assign w_target  = (count > DEPTH_W) ? DEPTH_W : count;
    assign w_nv_inc  = r_n_valid + (AW + 1)'(1);
    // Fires on the wait cycle in which the counter would step onto TIMEOUT.
    assign w_timeout = (r_cnt == TO_LAST);
    assign w_rd_hit  = ({1'b0, rd_addr} < r_n_valid);

    // Buffer is deliberately unreset; n_valid masks stale entries on readback.
    always_ff @(posedge clk) begin
        if (r_state == S_CAPTURE && !gen_error) begin
            r_buf[r_n_valid[AW-1:0]] <= gen_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_target    <= '0;
            r_cnt       <= '0;
            r_n_valid   <= '0;
            r_fail_code <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_gen_go    <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
            r_gen_go  <= 1'b0;
            r_rd_data <= w_rd_hit ? r_buf[rd_addr] : '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_target    <= w_target;
                        r_n_valid   <= '0;
                        r_fail_code <= 2'd0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        if (w_target == '0) begin
                            r_state <= S_FIN;
                        end else if (gen_ready) begin
                            r_state <= S_CAPTURE;
                        end else begin
                            r_state <= S_WAIT_HIGH;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (gen_error) begin
                        r_fail_code <= 2'd1;
                        r_state     <= S_FIN;
                    end else begin
                        r_n_valid <= w_nv_inc;
                        if (w_nv_inc == r_target) begin
                            r_state <= S_FIN;
                        end else begin
                            r_gen_go <= 1'b1;
                            r_state  <= S_GO;
                        end
                    end
                end
                S_GO: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (w_timeout) begin
                        r_fail_code <= 2'd2;
                        r_state     <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                        if (!gen_ready) begin
                            r_state <= S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_timeout) begin
                        r_fail_code <= 2'd2;
                        r_state     <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                        if (gen_ready) begin
                            r_state <= S_CAPTURE;
                        end
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (r_fail_code != 2'd0) begin
                        r_fail <= 1'b1;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign fail      = r_fail;
    assign fail_code = r_fail_code;
    assign n_valid   = r_n_valid;
    assign rd_data   = r_rd_data;
    assign gen_go    = r_gen_go;

endmodule

// File: tb/tb_primogen_drv.sv
// Bench for primogen_drv: a behavioural prime generator stub on the handshake, a sieve
// model of the expected result sequence, and directed runs covering each failure path.
module tb_primogen_drv;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int TIMEOUT = 20;
    localparam int TW      = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [AW:0]      count = '0;
    logic [AW-1:0]    rd_addr = '0;
    logic             busy, done, fail, gen_go;
    logic [1:0]       fail_code;
    logic [AW:0]      n_valid;
    logic [WIDTH-1:0] rd_data;
    logic             gen_ready, gen_error;
    logic [WIDTH-1:0] gen_res;

    primogen_drv #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .busy(busy), .done(done),
        .fail(fail), .fail_code(fail_code), .n_valid(n_valid), .rd_addr(rd_addr),
        .rd_data(rd_data), .gen_go(gen_go), .gen_ready(gen_ready), .gen_error(gen_error),
        .gen_res(gen_res)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic bit is_prime(int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int next_prime(int x);
        int n = x + 1;
        while (!is_prime(n)) n++;
        return n;
    endfunction

    // Generator stub: mode 0 normal, 1 never re-raises ready, 2 errors with its 3rd ready.
    int       g_mode = 0;
    logic [3:0] g_lat;
    int       g_nready;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_ready <= 1'b1;
            gen_res   <= 16'd1;
            gen_error <= 1'b0;
            g_lat     <= 4'd0;
            g_nready  <= 1;
        end else if (gen_go) begin
            gen_ready <= 1'b0;
            gen_error <= 1'b0;
            g_lat     <= 4'd3;
        end else if (g_lat != 4'd0) begin
            g_lat <= g_lat - 4'd1;
            if (g_lat == 4'd1 && g_mode != 1) begin
                gen_ready <= 1'b1;
                gen_res   <= 16'(next_prime(int'(gen_res)));
                g_nready  <= g_nready + 1;
                if (g_mode == 2 && g_nready == 2) gen_error <= 1'b1;
            end
        end
    end

    // Model: the generator's output sequence after reset, built with a sieve.
    int m_seq [DEPTH];
    int m_nvalid = 0;
    bit chk_en = 1'b0;

    int cyc = 0;
    int go_cnt = 0, done_cnt = 0, fail_cnt = 0;
    int go_cyc = 0, done_cyc = 0, fail_cyc = 0;
    bit prev_go = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                check("go_width", 32'(gen_go & prev_go), 0);
                check("go_busy", 32'(gen_go & ~busy), 0);
                check("done_fail_excl", 32'(done & fail), 0);
                check("pulse_busy", 32'((done | fail) & busy), 0);
                check("nv_max", 32'(n_valid > 6'(DEPTH)), 0);
                prev_go = gen_go;
                if (gen_go) begin go_cnt++; go_cyc = cyc; end
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (fail) begin fail_cnt++; fail_cyc = cyc; end
                if (chk_en) begin
                    check("rd_model", 32'(rd_data),
                          (int'(rd_addr) < m_nvalid) ? m_seq[rd_addr] : 0);
                    check("nv_model", 32'(n_valid), m_nvalid);
                end
            end else begin
                prev_go = 1'b0;
            end
        end
    end

    int b_go, b_done, b_fail, s_cyc;

    task automatic do_reset();
        @(negedge clk); #1;
        chk_en = 1'b0;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run(input int cnt);
        @(negedge clk); #1;
        chk_en = 1'b0;
        b_go = go_cnt; b_done = done_cnt; b_fail = fail_cnt;
        count = 6'(cnt);
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        count = 6'(DEPTH - 1);
    endtask

    task automatic wait_end(input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt + fail_cnt > b_done + b_fail) break;
            @(negedge clk); #1;
        end
        if (done_cnt + fail_cnt == b_done + b_fail) check(nm, 0, 1);
    endtask

    task automatic rd(input int a, input int exp, input string nm);
        @(negedge clk); #1;
        rd_addr = 5'(a);
        @(negedge clk); #1;
        check(nm, 32'(rd_data), exp);
    endtask

    int lit13 [13] = '{1, 2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37};

    initial begin
        begin
            bit comp [200];
            int k = 1;
            m_seq[0] = 1;
            for (int n = 2; n < 200; n++) begin
                if (!comp[n]) begin
                    if (k < DEPTH) begin m_seq[k] = n; k++; end
                    for (int m = n * n; m < 200; m += n) comp[m] = 1'b1;
                end
            end
        end
        check("model_seq5", m_seq[5], 11);
        check("model_seq12", m_seq[12], 37);
        check("model_seq31", m_seq[31], 127);

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_code", 32'(fail_code), 0);
        check("rst_nv", 32'(n_valid), 0);
        check("rst_rd", 32'(rd_data), 0);
        check("rst_go", 32'(gen_go), 0);
        rst = 1'b0;

        // Thirteen primes from a freshly reset generator.
        g_mode = 0;
        run(13);
        wait_end(600, "t1_end");
        check("t1_done", done_cnt - b_done, 1);
        check("t1_fail", fail_cnt - b_fail, 0);
        check("t1_nv", 32'(n_valid), 13);
        check("t1_go", go_cnt - b_go, 12);
        m_nvalid = 13;
        chk_en = 1'b1;
        for (int i = 0; i < 13; i++) rd(i, lit13[i], "t1_rd");
        rd(13, 0, "t1_rd_past");

        // Zero-length run: FIN immediately, done two cycles after the start cycle.
        run(0);
        wait_end(20, "t2_end");
        check("t2_lat", done_cyc - s_cyc, 2);
        check("t2_done", done_cnt - b_done, 1);
        check("t2_fail", fail_cnt - b_fail, 0);
        check("t2_go", go_cnt - b_go, 0);
        check("t2_nv", 32'(n_valid), 0);
        m_nvalid = 0;
        chk_en = 1'b1;
        rd(0, 0, "t2_rd");

        // Generator never re-raises ready: 20 wait cycles, then FIN, then the pulse.
        do_reset();
        g_mode = 1;
        run(5);
        wait_end(200, "t3_end");
        check("t3_fail", fail_cnt - b_fail, 1);
        check("t3_code", 32'(fail_code), 2);
        check("t3_nv", 32'(n_valid), 1);
        check("t3_go", go_cnt - b_go, 1);
        check("t3_lat", fail_cyc - go_cyc, TIMEOUT + 2);
        m_nvalid = 1;
        chk_en = 1'b1;
        rd(0, 1, "t3_rd0");
        rd(1, 0, "t3_rd1");
        check("t3_code_hold", 32'(fail_code), 2);

        // Generator error arrives with its third ready.
        do_reset();
        g_mode = 2;
        run(8);
        wait_end(200, "t4_end");
        check("t4_fail", fail_cnt - b_fail, 1);
        check("t4_done", done_cnt - b_done, 0);
        check("t4_code", 32'(fail_code), 1);
        check("t4_nv", 32'(n_valid), 2);
        m_nvalid = 2;
        chk_en = 1'b1;
        rd(0, 1, "t4_rd0");
        rd(1, 2, "t4_rd1");
        rd(2, 0, "t4_rd2");

        // Oversized count clamps to DEPTH; a start while busy is ignored.
        do_reset();
        g_mode = 0;
        run(40);
        repeat (10) @(negedge clk);
        #1;
        check("t5_busy_mid", 32'(busy), 1);
        count = 6'd3;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_end(1000, "t5_end");
        check("t5_nv", 32'(n_valid), 32);
        check("t5_go", go_cnt - b_go, 31);
        repeat (10) @(negedge clk);
        #1;
        check("t5_done_once", done_cnt - b_done, 1);
        check("t5_idle", 32'(busy), 0);
        check("t5_nv_hold", 32'(n_valid), 32);
        m_nvalid = 32;
        chk_en = 1'b1;
        rd(31, 127, "t5_rd31");
        rd(0, 1, "t5_rd0");

        // Reset while waiting for ready to rise, then a normal run.
        do_reset();
        run(5);
        for (int i = 0; i < 50; i++) begin
            if (go_cnt > b_go) break;
            @(negedge clk); #1;
        end
        if (go_cnt == b_go) check("t6_go_wait", 0, 1);
        repeat (3) @(negedge clk);
        #1;
        check("t6_busy_pre", 32'(busy), 1);
        check("t6_nv_pre", 32'(n_valid), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_go", 32'(gen_go), 0);
        check("t6_rst_nv", 32'(n_valid), 0);
        @(negedge clk); #1;
        rst = 1'b0;
        run(3);
        wait_end(200, "t6_end");
        check("t6_done", done_cnt - b_done, 1);
        check("t6_nv", 32'(n_valid), 3);
        check("t6_go", go_cnt - b_go, 2);
        m_nvalid = 3;
        chk_en = 1'b1;
        rd(0, 1, "t6_rd0");
        rd(1, 2, "t6_rd1");
        rd(2, 3, "t6_rd2");
        rd(3, 0, "t6_rd3");

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

endmodule
